uart_tx_arb: RTL



---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_gen.sv | 35 +++
 rtl/uart_tx_arb.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit arbiter
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int UART_CLKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } uart_arb_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running baud counter producing a one-cycle txclken pulse
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic txclk,
    input  logic rst_n,
    output logic txclken
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          txclken_q, txclken_d;

    // Pulse is registered off the terminal count, so the first one lands CLKS_PER_BIT edges after reset.
    always_comb begin
        txclken_d = (cnt_q == CW'(CLKS_PER_BIT - 1));
        cnt_d     = txclken_d ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge txclk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            txclken_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            txclken_q <= txclken_d;
        end
    end

    assign txclken = txclken_q;

endmodule

// File: rtl/uart_tx_arb.sv
// rtl/uart_tx_arb.sv - round-robin arbiter sharing one UART transmitter; UART_ARB_BURST_EN enables multi-byte grants
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int NREQ         = 4,
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int BUSY_TMO     = 8,
    parameter int BURST_LEN    = 4
) (
    input  logic                          txclk,
    input  logic                          rst_n,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [UART_DATA_W*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]               req_ready,
    output logic [UART_DATA_W-1:0]        tx_din,
    output logic                          tx_wr_en,
    input  logic                          tx_busy,
    output logic                          txclken,
    output logic [$clog2(NREQ)-1:0]       grant_id,
    output logic                          tmo_err
);

    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(BUSY_TMO + 1);
    localparam int BW = $clog2(BURST_LEN + 1);
`ifdef UART_ARB_BURST_EN
    localparam bit BURST_EN = 1'b1;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    uart_arb_state_t        state_q, state_d;
    logic [IW-1:0]          grant_q, grant_d;
    logic [IW-1:0]          ptr_q, ptr_d;
    logic [UART_DATA_W-1:0] din_q, din_d;
    logic                   wr_en_q, wr_en_d;
    logic [NREQ-1:0]        ready_q, ready_d;
    logic [TW-1:0]          tmo_cnt_q, tmo_cnt_d;
    logic                   tmo_err_q, tmo_err_d;
    logic [BW-1:0]          burst_q, burst_d;
    logic [IW-1:0]          pick;
    logic [IW-1:0]          nxt;

    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] v, input logic [IW-1:0] p);
        logic [IW-1:0] idx;
        logic          found;
        rr_pick = p;
        found   = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IW'((int'(p) + k) % NREQ);
            if (!found && v[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        pick      = rr_pick(req_valid, ptr_q);
        nxt       = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
        state_d   = state_q;
        grant_d   = grant_q;
        ptr_d     = ptr_q;
        din_d     = din_q;
        wr_en_d   = 1'b0;
        ready_d   = '0;
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = tmo_err_q;
        burst_d   = burst_q;
        case (state_q)
            IDLE: begin
                if (!tx_busy && (|req_valid)) begin
                    grant_d = pick;
                    din_d   = req_data[UART_DATA_W*int'(pick) +: UART_DATA_W];
                    wr_en_d = 1'b1;
                    ready_d = NREQ'(1) << pick;
                    burst_d = BW'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                tmo_cnt_d = TW'(BUSY_TMO - 1);
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (tmo_cnt_q == '0) begin
                    tmo_err_d = 1'b1;
                    ptr_d     = nxt;
                    state_d   = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - TW'(1);
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    // A burst keeps the grant and skips re-arbitration entirely.
                    if (BURST_EN && req_valid[grant_q] && (burst_q < BW'(BURST_LEN))) begin
                        din_d   = req_data[UART_DATA_W*int'(grant_q) +: UART_DATA_W];
                        wr_en_d = 1'b1;
                        ready_d = NREQ'(1) << grant_q;
                        burst_d = burst_q + BW'(1);
                        state_d = ISSUE;
                    end else begin
                        ptr_d   = nxt;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge txclk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            ptr_q     <= '0;
            din_q     <= '0;
            wr_en_q   <= 1'b0;
            ready_q   <= '0;
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
            burst_q   <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            ptr_q     <= ptr_d;
            din_q     <= din_d;
            wr_en_q   <= wr_en_d;
            ready_q   <= ready_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
            burst_q   <= burst_d;
        end
    end

    assign req_ready = ready_q;
    assign tx_din    = din_q;
    assign tx_wr_en  = wr_en_q;
    assign grant_id  = grant_q;
    assign tmo_err   = tmo_err_q;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .txclk   (txclk),
        .rst_n   (rst_n),
        .txclken (txclken)
    );

endmodule
